// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: ALU codes, opcode/funct constants, state codes, instruction classes and select codes for the MCCPU control
package mc_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;
  typedef enum logic [3:0] {C_R, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_ILL} cls_t;
  localparam logic [2:0] ALU_NOP  = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_SLT  = 3'd5;
  localparam logic [2:0] ALU_SLTU = 3'd6;
  localparam logic [2:0] ALU_NOR  = 3'd7;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;
  localparam logic [1:0] SRCB_RT  = 2'd0;
  localparam logic [1:0] SRCB_4   = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;
  localparam logic [1:0] SRCB_BR  = 2'd3;
  localparam logic [1:0] PC_ALU = 2'd0;
  localparam logic [1:0] PC_OUT = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;
  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MDR = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;
endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: control bundle between mc_ctrl (slave) and the MCCPU datapath (master)
//   op/funct/zero/mem_rdy flow into the controller; enables, selects, state and instret flow out
interface mc_ctrl_if #(parameter int CNT_W = 32);
  logic [5:0] op, funct;
  logic zero, mem_rdy;
  logic pc_write, ir_write, reg_write, mem_read, mem_write, iord, alu_srca, ext_op, illegal;
  logic [2:0] alu_op, state;
  logic [1:0] alu_srcb, pc_src, reg_dst, wd_sel;
  logic [CNT_W-1:0] instret;
  modport master (
    output op, funct, zero, mem_rdy,
    input pc_write, ir_write, reg_write, mem_read, mem_write, iord, alu_srca, ext_op, illegal,
    input alu_op, state, alu_srcb, pc_src, reg_dst, wd_sel, instret
  );
  modport slave (
    input op, funct, zero, mem_rdy,
    output pc_write, ir_write, reg_write, mem_read, mem_write, iord, alu_srca, ext_op, illegal,
    output alu_op, state, alu_srcb, pc_src, reg_dst, wd_sel, instret
  );
endinterface

// File: rtl/mc_decode.sv
// mc_decode: op/funct -> instruction class, EXE-stage ALU operation, sign-extend flag, legal flag
//   op, funct : IR fields;  cls, alu, sext, legal : decoded instruction attributes
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic [2:0] alu,
  output logic       sext,
  output logic       legal
);
  logic [2:0] r_alu;
  always_comb begin
    r_alu = funct == F_ADD  ? ALU_ADD :
            funct == F_SUB  ? ALU_SUB :
            funct == F_AND  ? ALU_AND :
            funct == F_OR   ? ALU_OR  :
            funct == F_SLT  ? ALU_SLT :
            funct == F_SLTU ? ALU_SLTU :
            funct == F_NOR  ? ALU_NOR : ALU_NOP;
    cls = op == OP_R ? (r_alu == ALU_NOP ? C_ILL : C_R) :
          (op == OP_ADDI || op == OP_SLTI || op == OP_ANDI || op == OP_ORI) ? C_IALU :
          op == OP_LW  ? C_LW  :
          op == OP_SW  ? C_SW  :
          op == OP_BEQ ? C_BEQ :
          op == OP_BNE ? C_BNE :
          op == OP_J   ? C_J   :
          op == OP_JAL ? C_JAL : C_ILL;
    alu = cls == C_R ? r_alu :
          (cls == C_BEQ || cls == C_BNE) ? ALU_SUB :
          op == OP_SLTI ? ALU_SLT :
          op == OP_ANDI ? ALU_AND :
          op == OP_ORI  ? ALU_OR  :
          (op == OP_ADDI || cls == C_LW || cls == C_SW) ? ALU_ADD : ALU_NOP;
    sext = op == OP_ADDI || op == OP_SLTI || op == OP_LW || op == OP_SW;
    legal = cls != C_ILL;
  end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MCCPU control FSM with memory-ready stalls and retired-instruction counter
//   clk : rising-edge clock;  rst : asynchronous active-high reset
//   bus : mc_ctrl_if.slave -- IR op/funct, ALU zero, mem_rdy in; enables, selects, state, instret out
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input logic      clk,
  input logic      rst,
  mc_ctrl_if.slave bus
);
  state_t state, nxt;
  cls_t cls;
  logic [2:0] alu;
  logic sext, legal, br, jmp, ret;
  logic [CNT_W-1:0] cnt;
  mc_decode u_dec (.op(bus.op), .funct(bus.funct), .cls(cls), .alu(alu), .sext(sext), .legal(legal));
  assign br = cls == C_BEQ || cls == C_BNE;
  assign jmp = cls == C_J || cls == C_JAL;
  // Asserted in the last cycle of a legal instruction; the count updates on the edge that leaves it.
  assign ret = state == S_WB || (state == S_EXE && br) || (state == S_ID && jmp) ||
               (state == S_MEM && cls == C_SW && bus.mem_rdy);
  assign bus.state = state;
  assign bus.instret = cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IF;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt + CNT_W'(ret);
    end
  always_comb begin
    nxt = S_IF;
    bus.pc_write = 1'b0;
    bus.ir_write = 1'b0;
    bus.reg_write = 1'b0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.iord = 1'b0;
    bus.alu_op = ALU_NOP;
    bus.alu_srca = 1'b0;
    bus.alu_srcb = SRCB_RT;
    bus.ext_op = 1'b0;
    bus.pc_src = PC_ALU;
    bus.reg_dst = RD_RT;
    bus.wd_sel = WD_ALU;
    bus.illegal = 1'b0;
    // State resets asynchronously to IF, whose outputs are non-zero, so outputs are gated while rst is high.
    if (!rst)
      case (state)
        S_IF: begin
          bus.mem_read = 1'b1;
          bus.alu_op = ALU_ADD;
          bus.alu_srcb = SRCB_4;
          bus.ir_write = bus.mem_rdy;
          bus.pc_write = bus.mem_rdy;
          nxt = bus.mem_rdy ? S_ID : S_IF;
        end
        S_ID: begin
          bus.alu_op = ALU_ADD;
          bus.alu_srcb = SRCB_BR;
          bus.illegal = !legal;
          bus.pc_write = jmp;
          bus.pc_src = jmp ? PC_JMP : PC_ALU;
          bus.reg_write = cls == C_JAL;
          bus.reg_dst = cls == C_JAL ? RD_RA : RD_RT;
          bus.wd_sel = cls == C_JAL ? WD_PC : WD_ALU;
          nxt = !legal ? (ILLEGAL_TRAP ? S_HALT : S_IF) : jmp ? S_IF : S_EXE;
        end
        S_EXE: begin
          bus.alu_op = alu;
          bus.alu_srca = 1'b1;
          bus.alu_srcb = (cls == C_R || br) ? SRCB_RT : SRCB_IMM;
          bus.ext_op = sext;
          bus.pc_src = br ? PC_OUT : PC_ALU;
          bus.pc_write = (cls == C_BEQ && bus.zero) || (cls == C_BNE && !bus.zero);
          nxt = br ? S_IF : (cls == C_LW || cls == C_SW) ? S_MEM : S_WB;
        end
        S_MEM: begin
          bus.iord = 1'b1;
          bus.mem_read = cls == C_LW;
          bus.mem_write = cls == C_SW;
          nxt = !bus.mem_rdy ? S_MEM : cls == C_LW ? S_WB : S_IF;
        end
        S_WB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst = cls == C_R ? RD_RD : RD_RT;
          bus.wd_sel = cls == C_LW ? WD_MDR : WD_ALU;
        end
        S_HALT: nxt = S_HALT;
        default: nxt = S_IF;
      endcase
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: cycle-trace table, reset/halt/wrap sequences and randomized instruction stream for mc_ctrl
module tb_mc_ctrl;
  localparam int W = 4;
  localparam int NOP = 0, ADD = 1, SUB = 2, AND_ = 3, OR_ = 4;
  typedef struct packed {
    logic pw, irw, rw, mr, mw, io;
    logic [2:0] aop;
    logic sa;
    logic [1:0] sb;
    logic ext;
    logic [1:0] ps, rd, wd;
    logic il;
  } ctl_t;
  typedef struct {
    int op, fn, z, rdy, st;
    ctl_t ctl;
    int cnt;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  vec_t tv[$];
  ctl_t if_go, if_wt, id_n, id_j, id_jal, id_il, ex_add, ex_sub, ex_b1, ex_b0, ex_mem, ex_ori;
  ctl_t mem_l, mem_s, wb_r, wb_i, wb_l;
  int rop[20] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C,
                  6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F, 6'h00, 6'h10};
  int rfn[20] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h27, 0, 0, 0,
                  0, 0, 0, 0, 0, 0, 0, 0, 6'h01, 0};
  int lat[8] = '{2, 4, 5, 4, 3, 3, 2, 2};
  always #5 clk = ~clk;
  mc_ctrl_if #(.CNT_W(W)) m();
  mc_ctrl_if #(.CNT_W(W)) t();
  assign t.op = m.op;
  assign t.funct = m.funct;
  assign t.zero = m.zero;
  assign t.mem_rdy = m.mem_rdy;
  mc_ctrl #(.CNT_W(W), .ILLEGAL_TRAP(1'b0)) dut (.clk(clk), .rst(rst), .bus(m.slave));
  mc_ctrl #(.CNT_W(W), .ILLEGAL_TRAP(1'b1)) dut_t (.clk(clk), .rst(rst), .bus(t.slave));
  function automatic ctl_t c(input int pw, irw, rw, mr, mw, io, aop, sa, sb, ext, ps, rd, wd, il);
    return {pw[0], irw[0], rw[0], mr[0], mw[0], io[0], aop[2:0], sa[0], sb[1:0], ext[0], ps[1:0], rd[1:0], wd[1:0], il[0]};
  endfunction
  function automatic ctl_t outs();
    return {m.pc_write, m.ir_write, m.reg_write, m.mem_read, m.mem_write, m.iord, m.alu_op, m.alu_srca,
            m.alu_srcb, m.ext_op, m.pc_src, m.reg_dst, m.wd_sel, m.illegal};
  endfunction
  function automatic void vec(input int op, fn, z, rdy, st, input ctl_t ctl, input int cnt);
    tv.push_back('{op, fn, z, rdy, st, ctl, cnt});
  endfunction
  // Instruction kind from the opcode map: 0 illegal, 1 R/I-ALU, 2 lw, 3 sw, 4 beq, 5 bne, 6 j, 7 jal
  function automatic int kind(input int op, fn);
    case (op)
      6'h00: return (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h27}) ? 1 : 0;
      6'h08, 6'h0A, 6'h0C, 6'h0D: return 1;
      6'h23: return 2;
      6'h2B: return 3;
      6'h04: return 4;
      6'h05: return 5;
      6'h02: return 6;
      6'h03: return 7;
      default: return 0;
    endcase
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, exp);
    end
  endtask
  task automatic drive(input int op, fn, z, rdy);
    @(posedge clk);
    #1;
    m.op = op[5:0];
    m.funct = fn[5:0];
    m.zero = z[0];
    m.mem_rdy = rdy[0];
    #1;
  endtask
  initial begin
    int k, k1, k2, cy, nrw, npw, nmw, nmr, nil, z, rdy, exp_cnt, ecy;
    logic [2:0] st;
    if_go  = c(1, 1, 0, 1, 0, 0, ADD, 0, 1, 0, 0, 0, 0, 0);
    if_wt  = c(0, 0, 0, 1, 0, 0, ADD, 0, 1, 0, 0, 0, 0, 0);
    id_n   = c(0, 0, 0, 0, 0, 0, ADD, 0, 3, 0, 0, 0, 0, 0);
    id_j   = c(1, 0, 0, 0, 0, 0, ADD, 0, 3, 0, 2, 0, 0, 0);
    id_jal = c(1, 0, 1, 0, 0, 0, ADD, 0, 3, 0, 2, 2, 2, 0);
    id_il  = c(0, 0, 0, 0, 0, 0, ADD, 0, 3, 0, 0, 0, 0, 1);
    ex_add = c(0, 0, 0, 0, 0, 0, ADD, 1, 0, 0, 0, 0, 0, 0);
    ex_sub = c(0, 0, 0, 0, 0, 0, SUB, 1, 0, 0, 0, 0, 0, 0);
    ex_b1  = c(1, 0, 0, 0, 0, 0, SUB, 1, 0, 0, 1, 0, 0, 0);
    ex_b0  = c(0, 0, 0, 0, 0, 0, SUB, 1, 0, 0, 1, 0, 0, 0);
    ex_mem = c(0, 0, 0, 0, 0, 0, ADD, 1, 2, 1, 0, 0, 0, 0);
    ex_ori = c(0, 0, 0, 0, 0, 0, OR_, 1, 2, 0, 0, 0, 0, 0);
    mem_l  = c(0, 0, 0, 1, 0, 1, NOP, 0, 0, 0, 0, 0, 0, 0);
    mem_s  = c(0, 0, 0, 0, 1, 1, NOP, 0, 0, 0, 0, 0, 0, 0);
    wb_r   = c(0, 0, 1, 0, 0, 0, NOP, 0, 0, 0, 0, 1, 0, 0);
    wb_i   = c(0, 0, 1, 0, 0, 0, NOP, 0, 0, 0, 0, 0, 0, 0);
    wb_l   = c(0, 0, 1, 0, 0, 0, NOP, 0, 0, 0, 0, 0, 1, 0);
    vec(6'h00, 6'h20, 0, 1, 0, if_go, 0); vec(6'h00, 6'h20, 0, 1, 1, id_n, 0);
    vec(6'h00, 6'h20, 0, 1, 2, ex_add, 0); vec(6'h00, 6'h20, 0, 1, 4, wb_r, 0);
    vec(6'h04, 0, 1, 1, 0, if_go, 1); vec(6'h04, 0, 1, 1, 1, id_n, 1); vec(6'h04, 0, 1, 1, 2, ex_b1, 1);
    vec(6'h04, 0, 0, 1, 0, if_go, 2); vec(6'h04, 0, 0, 1, 1, id_n, 2); vec(6'h04, 0, 0, 1, 2, ex_b0, 2);
    vec(6'h23, 0, 0, 0, 0, if_wt, 3); vec(6'h23, 0, 0, 0, 0, if_wt, 3); vec(6'h23, 0, 0, 1, 0, if_go, 3);
    vec(6'h23, 0, 0, 1, 1, id_n, 3); vec(6'h23, 0, 0, 1, 2, ex_mem, 3); vec(6'h23, 0, 0, 0, 3, mem_l, 3);
    vec(6'h23, 0, 0, 0, 3, mem_l, 3); vec(6'h23, 0, 0, 1, 3, mem_l, 3); vec(6'h23, 0, 0, 1, 4, wb_l, 3);
    vec(6'h03, 0, 0, 1, 0, if_go, 4); vec(6'h03, 0, 0, 1, 1, id_jal, 4);
    vec(6'h02, 0, 0, 1, 0, if_go, 5); vec(6'h02, 0, 0, 1, 1, id_j, 5);
    vec(6'h3F, 0, 0, 1, 0, if_go, 6); vec(6'h3F, 0, 0, 1, 1, id_il, 6);
    vec(6'h2B, 0, 0, 1, 0, if_go, 6); vec(6'h2B, 0, 0, 1, 1, id_n, 6);
    vec(6'h2B, 0, 0, 1, 2, ex_mem, 6); vec(6'h2B, 0, 0, 1, 3, mem_s, 6);
    vec(6'h05, 0, 0, 1, 0, if_go, 7); vec(6'h05, 0, 0, 1, 1, id_n, 7); vec(6'h05, 0, 0, 1, 2, ex_b1, 7);
    vec(6'h08, 0, 0, 1, 0, if_go, 8); vec(6'h08, 0, 0, 1, 1, id_n, 8);
    vec(6'h08, 0, 0, 1, 2, ex_mem, 8); vec(6'h08, 0, 0, 1, 4, wb_i, 8);
    vec(6'h0D, 0, 0, 1, 0, if_go, 9); vec(6'h0D, 0, 0, 1, 1, id_n, 9);
    vec(6'h0D, 0, 0, 1, 2, ex_ori, 9); vec(6'h0D, 0, 0, 1, 4, wb_i, 9);
    vec(6'h00, 6'h22, 0, 1, 0, if_go, 10); vec(6'h00, 6'h22, 0, 1, 1, id_n, 10);
    vec(6'h00, 6'h22, 0, 1, 2, ex_sub, 10); vec(6'h00, 6'h22, 0, 1, 4, wb_r, 10);
    vec(6'h00, 6'h3F, 0, 1, 0, if_go, 11); vec(6'h00, 6'h3F, 0, 1, 1, id_il, 11);
    vec(6'h00, 6'h20, 0, 0, 0, if_wt, 11);
    m.op = '0; m.funct = '0; m.zero = 1'b0; m.mem_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ctl", 32'(outs()), 32'(ctl_t'(0)));
    chk("rst_state", 32'(m.state), 0);
    chk("rst_cnt", 32'(m.instret), 0);
    m.mem_rdy = 1'b0;
    @(negedge clk) rst = 1'b0;
    foreach (tv[i]) begin
      drive(tv[i].op, tv[i].fn, tv[i].z, tv[i].rdy);
      chk($sformatf("v%0d_state", i), 32'(m.state), tv[i].st);
      chk($sformatf("v%0d_ctl", i), 32'(outs()), 32'(tv[i].ctl));
      chk($sformatf("v%0d_cnt", i), 32'(m.instret), tv[i].cnt);
    end
    drive(6'h2B, 0, 0, 1); drive(6'h2B, 0, 0, 1); drive(6'h2B, 0, 0, 1); drive(6'h2B, 0, 0, 0);
    chk("sw_mem_write", 32'(m.mem_write), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_ctl", 32'(outs()), 32'(ctl_t'(0)));
    chk("rst_mid_state", 32'(m.state), 0);
    chk("rst_mid_cnt", 32'(m.instret), 0);
    m.mem_rdy = 1'b0;
    @(negedge clk) rst = 1'b0;
    drive(6'h2B, 0, 0, 0);
    chk("post_rst_state", 32'(m.state), 0);
    chk("post_rst_ctl", 32'(outs()), 32'(if_wt));
    drive(6'h3F, 0, 0, 1);
    drive(6'h3F, 0, 0, 1);
    chk("trap_illegal", 32'(t.illegal), 1);
    chk("main_illegal", 32'(m.illegal), 1);
    for (int i = 0; i < 4; i++) begin
      drive(6'h3F, 0, 0, 1);
      chk($sformatf("halt%0d_state", i), 32'(t.state), 5);
      chk($sformatf("halt%0d_en", i), 32'({t.pc_write, t.ir_write, t.reg_write, t.mem_read, t.mem_write, t.illegal}), 0);
    end
    chk("halt_cnt", 32'(t.instret), 0);
    chk("main_ill_cnt", 32'(m.instret), 0);
    @(negedge clk) begin rst = 1'b1; m.mem_rdy = 1'b0; end
    @(negedge clk) rst = 1'b0;
    drive(0, 0, 0, 0);
    chk("halt_exit_state", 32'(t.state), 0);
    chk("main_rst_state", 32'(m.state), 0);
    for (int i = 0; i < 16; i++) begin
      drive(6'h02, 0, 0, 1);
      chk($sformatf("wrap%0d_cnt", i), 32'(m.instret), i);
      drive(6'h02, 0, 0, 1);
    end
    drive(6'h02, 0, 0, 0);
    chk("wrap_zero", 32'(m.instret), 0);
    exp_cnt = 0;
    @(posedge clk);
    #1;
    for (int n = 0; n < 60; n++) begin
      int idx;
      idx = $urandom_range(0, 19);
      k = kind(rop[idx], rfn[idx]);
      k1 = $urandom_range(0, 3);
      k2 = $urandom_range(0, 3);
      z = $urandom_range(0, 1);
      cy = 0; nrw = 0; npw = 0; nmw = 0; nmr = 0; nil = 0;
      st = 3'd0;
      while (cy < 64) begin
        rdy = (cy < k1 || (cy >= k1 + 3 && cy < k1 + 3 + k2)) ? 0 : 1;
        m.op = rop[idx][5:0]; m.funct = rfn[idx][5:0]; m.zero = z[0]; m.mem_rdy = rdy[0];
        #1;
        st = m.state;
        nrw += int'(m.reg_write); npw += int'(m.pc_write); nmw += int'(m.mem_write);
        nmr += int'(m.mem_read); nil += int'(m.illegal);
        cy++;
        @(posedge clk);
        #1;
        if (m.state == 3'd0 && st != 3'd0) break;
      end
      ecy = lat[k] + k1 + ((k == 2 || k == 3) ? k2 : 0);
      exp_cnt += (k != 0) ? 1 : 0;
      chk($sformatf("r%0d_cycles", n), cy, ecy);
      chk($sformatf("r%0d_reg_write", n), nrw, (k == 1 || k == 2 || k == 7) ? 1 : 0);
      chk($sformatf("r%0d_pc_write", n), npw, 1 + ((k >= 6) ? 1 : 0) + ((k == 4 && z == 1) || (k == 5 && z == 0) ? 1 : 0));
      chk($sformatf("r%0d_mem_write", n), nmw, (k == 3) ? k2 + 1 : 0);
      chk($sformatf("r%0d_mem_read", n), nmr, k1 + 1 + ((k == 2) ? k2 + 1 : 0));
      chk($sformatf("r%0d_illegal", n), nil, (k == 0) ? 1 : 0);
      chk($sformatf("r%0d_instret", n), 32'(m.instret), exp_cnt % (1 << W));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
